fir_cfg_ctrl: RTL and testbench
===============================

# fir_cfg_ctrl

Configuration and control front-end for the FIR engine. Terminates the AXI-Lite slave port, holds the ap_ctrl and data_length registers, runs the ap_start/ap_done/ap_idle state machine, and arbitrates the single-port tap coefficient BRAM between AXI-Lite accesses and the FIR datapath's tap address generator. The FIR datapath sits behind it and sees only a start pulse, the length register and a tap-RAM grant.

## Interface
- pADDR_WIDTH, 12, AXI-Lite / BRAM address width
- pDATA_WIDTH, 32, data width
- Tape_Num, 11, number of taps; tap region 0x20 .. 0x20+4*(Tape_Num-1)
- axis_clk  in  1  clock
- axis_rst_n  in  1  reset, asynchronous, active-low
- awvalid/awready, wvalid/wready  in/out  1 each  AXI-Lite write channels
- awaddr  in  pADDR_WIDTH; wdata  in  pDATA_WIDTH
- arvalid/arready  in/out  1; araddr  in  pADDR_WIDTH
- rvalid/rready  out/in  1; rdata  out  pDATA_WIDTH
- tap_WE  out  4; tap_EN  out  1; tap_Di  out  pDATA_WIDTH; tap_A  out  pADDR_WIDTH; tap_Do  in  pDATA_WIDTH  tap BRAM, 1-cycle read latency
- eng_tap_A  in  pADDR_WIDTH  engine tap byte address, used when engine owns RAM
- eng_done  in  1  one-cycle pulse when engine emits last output (sm_tlast accepted)
- ap_start_o  out  1  one-cycle start pulse to engine
- data_length_o  out  32  registered length
- eng_own  out  1  high while engine owns tap RAM (state RUN)

## Operation
- Address map (awaddr/araddr[7:0]): 0x00 ap_ctrl (bit0 start W1S, bit1 done RO, bit2 idle RO); 0x10 data_length RW; 0x20+ taps RW; else write dropped, read returns 0.
- ap FSM states IDLE (ap_ctrl=3'b100), RUN (3'b000), DONE (3'b110).
- IDLE/DONE -> RUN: accepted write to 0x00 with wdata[0]=1 and data_length!=0; ap_start_o high exactly the cycle after acceptance. data_length==0 start is ignored.
- RUN -> DONE on eng_done. DONE -> IDLE when a read of 0x00 completes (rvalid&&rready); that read returns 3'b110.
- Start write during RUN ignored. data_length and tap writes during RUN dropped; tap reads during RUN return 32'hFFFF_FFFF without touching BRAM; ap_ctrl reads allowed anytime.
- Tap mux: eng_own=1 -> tap_A=eng_tap_A, tap_WE=0; else tap_A=addr-0x20, tap_Di=wdata, tap_WE=4'hF only on accepted in-range tap write.
- tap_EN=1 whenever out of reset.

## Timing
- Write: when awvalid&&wvalid both high and write FSM idle, awready and wready pulse together for one cycle (registered, cycle N+1); register/BRAM write occurs in that cycle. awvalid without wvalid waits.
- Write has priority over read for BRAM when both arrive in same cycle; read is delayed one cycle.
- Read FSM: R_IDLE -> R_ADDR (arready=1 one cycle, tap_A driven) -> R_DATA (rvalid=1, rdata stable) held until rready; then R_IDLE. Latency arvalid -> rvalid = 2 cycles.
- eng_done in same cycle as completing 0x00 read: DONE is entered, read returns pre-update value, done stays set.
- Reset: awready=wready=arready=rvalid=0, rdata=0, ap_ctrl=3'b100, data_length=0, tap_WE=0, tap_EN=0, tap_A=0, tap_Di=0, ap_start_o=0, eng_own=0. Reset mid-transaction aborts it; no BRAM write issued.

## Test plan
- Write taps 0x20..0x48 with 0,-10,-9,23,56,63,56,23,-9,-10,0, read back -> identical values, rvalid 2 cycles after arvalid.
- Write 0x10=600, then 0x00=1 -> ap_start_o one pulse, 0x00 reads 0, eng_own=1.
- During RUN write tap 0x24=5 and read 0x24 -> no tap_WE, read returns 0xFFFFFFFF; later readback shows -10.
- Pulse eng_done -> 0x00 reads 3'b110 once, next read 3'b100.
- Start with data_length=0 -> no ap_start_o, stays 3'b100; start during RUN -> no second pulse.
- Assert axis_rst_n low mid-write -> all outputs to reset values, ap_ctrl=3'b100, data_length=0.

Source files
------------

// File: rtl/fir_cfg_if.sv
// fir_cfg_if
// AXI-Lite bundle between the host and the FIR configuration front-end.
// Ports (as signals of the interface):
//   awvalid/awready/awaddr  write-address channel
//   wvalid/wready/wdata     write-data channel
//   arvalid/arready/araddr  read-address channel
//   rvalid/rready/rdata     read-data channel
// Modports: master (host side), slave (fir_cfg_ctrl side).
interface fir_cfg_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_cfg_ctrl.sv
// fir_cfg_ctrl
// Configuration/control front-end of the FIR engine: AXI-Lite slave,
// ap_ctrl + data_length registers, ap_start/ap_done/ap_idle FSM and the
// arbiter of the single-port tap-coefficient BRAM.
// Ports:
//   axis_clk, axis_rst_n       clock, asynchronous active-low reset
//   axil                       AXI-Lite slave (fir_cfg_if.slave)
//   tap_WE/EN/Di/A, tap_Do     tap BRAM port (1-cycle read latency)
//   eng_tap_A                  engine tap address, used while engine owns RAM
//   eng_done                   engine finished (one-cycle pulse)
//   ap_start_o                 one-cycle start pulse to the engine
//   data_length_o              length register
//   eng_own                    engine owns the tap RAM (state RUN)
module fir_cfg_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  fir_cfg_if.slave               axil,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  input  logic                   eng_done,
  output logic                   ap_start_o,
  output logic [31:0]            data_length_o,
  output logic                   eng_own
);

  localparam logic [7:0] TAP_LO = 8'h20;
  localparam logic [7:0] TAP_HI = 8'(32'd32 + 32'(4 * (Tape_Num - 1)));

  // State encodings equal the ap_ctrl read value {idle, done, start}.
  typedef enum logic [2:0] {
    AP_IDLE = 3'b100,
    AP_RUN  = 3'b000,
    AP_DONE = 3'b110
  } ap_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  ap_state_t              ap_state;
  rd_state_t              rd_state;
  logic                   awready, wready, arready, rvalid;
  logic [7:0]             rd_addr;
  logic                   rd_run;        // read was accepted while engine owned the RAM
  logic                   rd_live;       // first R_DATA cycle of a BRAM read: pass tap_Do through
  logic                   rd_ctrl_done;  // in-flight read of 0x00 is returning done=1
  logic [pDATA_WIDTH-1:0] rdata_q;
  logic [pADDR_WIDTH-1:0] cfg_tap_a;
  logic [3:0]             cfg_we;
  logic                   wr_go, rd_go, rd_done_ctrl;
  logic [2:0]             ap_bits;

  function automatic logic is_tap(input logic [7:0] a8);
    return (a8 >= TAP_LO) && (a8 <= TAP_HI);
  endfunction

  function automatic logic [pADDR_WIDTH-1:0] tap_off(input logic [pADDR_WIDTH-1:0] a);
    return a - pADDR_WIDTH'(8'h20);
  endfunction

  // A write is taken only when both channels are valid and the previous
  // ready pulse is over; a read waits a cycle if a write is taken with it.
  assign wr_go        = axil.awvalid && axil.wvalid && !awready;
  assign rd_go        = (rd_state == R_IDLE) && axil.arvalid && !wr_go;
  assign rd_done_ctrl = (rd_state == R_DATA) && axil.rready && rd_ctrl_done;
  assign ap_bits      = ap_state;

  assign axil.awready = awready;
  assign axil.wready  = wready;
  assign axil.arready = arready;
  assign axil.rvalid  = rvalid;
  // BRAM data arrives one cycle after R_ADDR, so the first R_DATA cycle
  // forwards tap_Do; it is captured into rdata_q to stay stable afterwards.
  assign axil.rdata   = rd_live ? tap_Do : rdata_q;
  assign tap_A        = eng_own ? eng_tap_A : cfg_tap_a;
  assign tap_WE       = eng_own ? 4'h0 : cfg_we;

  // Write channel handshake, data_length register and ap_start/done/idle FSM.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      awready       <= 1'b0;
      wready        <= 1'b0;
      ap_state      <= AP_IDLE;
      ap_start_o    <= 1'b0;
      eng_own       <= 1'b0;
      data_length_o <= 32'd0;
    end else begin
      awready    <= wr_go;
      wready     <= wr_go;
      ap_start_o <= 1'b0;
      if (wr_go && (axil.awaddr[7:0] == 8'h10) && (ap_state != AP_RUN)) begin
        data_length_o <= 32'(axil.wdata);
      end
      case (ap_state)
        AP_IDLE, AP_DONE: begin
          if (wr_go && (axil.awaddr[7:0] == 8'h00) && axil.wdata[0] &&
              (data_length_o != 32'd0)) begin
            ap_state   <= AP_RUN;
            eng_own    <= 1'b1;
            ap_start_o <= 1'b1;
          end else if ((ap_state == AP_DONE) && rd_done_ctrl) begin
            ap_state <= AP_IDLE;
          end
        end
        AP_RUN: begin
          if (eng_done) begin
            ap_state <= AP_DONE;
            eng_own  <= 1'b0;
          end
        end
        default: begin
          ap_state <= AP_IDLE;
          eng_own  <= 1'b0;
        end
      endcase
    end
  end

  // Host-side tap BRAM port: write strobe, address and write data.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      tap_EN    <= 1'b0;
      cfg_we    <= 4'h0;
      cfg_tap_a <= '0;
      tap_Di    <= '0;
    end else begin
      tap_EN <= 1'b1;
      cfg_we <= 4'h0;
      if (wr_go && is_tap(axil.awaddr[7:0]) && (ap_state != AP_RUN)) begin
        cfg_we    <= 4'hF;
        cfg_tap_a <= tap_off(axil.awaddr);
        tap_Di    <= axil.wdata;
      end else if (rd_go && is_tap(axil.araddr[7:0]) && (ap_state != AP_RUN)) begin
        cfg_tap_a <= tap_off(axil.araddr);
      end
    end
  end

  // Read FSM: address phase (arready), then data phase held until rready.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rd_state     <= R_IDLE;
      arready      <= 1'b0;
      rvalid       <= 1'b0;
      rd_addr      <= 8'h00;
      rd_run       <= 1'b0;
      rd_live      <= 1'b0;
      rd_ctrl_done <= 1'b0;
      rdata_q      <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          rvalid  <= 1'b0;
          rd_live <= 1'b0;
          arready <= rd_go;
          if (rd_go) begin
            rd_state <= R_ADDR;
            rd_addr  <= axil.araddr[7:0];
            rd_run   <= (ap_state == AP_RUN);
          end
        end
        R_ADDR: begin
          arready      <= 1'b0;
          rvalid       <= 1'b1;
          rd_state     <= R_DATA;
          rd_live      <= 1'b0;
          rd_ctrl_done <= 1'b0;
          if (rd_addr == 8'h00) begin
            rdata_q      <= pDATA_WIDTH'(ap_bits);
            rd_ctrl_done <= (ap_state == AP_DONE);
          end else if (rd_addr == 8'h10) begin
            rdata_q <= pDATA_WIDTH'(data_length_o);
          end else if (is_tap(rd_addr)) begin
            if (rd_run) begin
              rdata_q <= '1;
            end else begin
              rd_live <= 1'b1;
            end
          end else begin
            rdata_q <= '0;
          end
        end
        R_DATA: begin
          rd_live <= 1'b0;
          if (rd_live) begin
            rdata_q <= tap_Do;
          end
          if (axil.rready) begin
            rvalid       <= 1'b0;
            rd_ctrl_done <= 1'b0;
            rd_state     <= R_IDLE;
          end
        end
        default: begin
          rd_state <= R_IDLE;
          arready  <= 1'b0;
          rvalid   <= 1'b0;
          rd_live  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// tb_fir_cfg_ctrl
// Self-checking bench for fir_cfg_ctrl: table of AXI-Lite writes/reads with a
// read scoreboard, plus hand-written sequences for start/run/done, blocked
// accesses during RUN, write/read collision and reset in mid-write.
module tb_fir_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do;
  logic [11:0] eng_tap_A = 12'h014;
  logic        eng_done = 1'b0;
  logic        ap_start_o;
  logic [31:0] data_length_o;
  logic        eng_own;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int we_cnt = 0;
  logic        last_start;
  logic [3:0]  last_we;
  logic [31:0] exp_q[$];
  logic [31:0] mem [16];

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;   // write data, or expected read data
    int          hold;   // cycles rready stays low after rvalid
  } vec_t;
  vec_t tbl[$];
  int   coef[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  fir_cfg_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) axil();

  fir_cfg_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
    .axis_clk     (clk),
    .axis_rst_n   (rst_n),
    .axil         (axil),
    .tap_WE       (tap_WE),
    .tap_EN       (tap_EN),
    .tap_Di       (tap_Di),
    .tap_A        (tap_A),
    .tap_Do       (tap_Do),
    .eng_tap_A    (eng_tap_A),
    .eng_done     (eng_done),
    .ap_start_o   (ap_start_o),
    .data_length_o(data_length_o),
    .eng_own      (eng_own)
  );

  always #5 clk = ~clk;

  // Tap BRAM: one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
      tap_Do <= mem[tap_A[5:2]];
    end
  end

  // Count start pulses and BRAM write strobes.
  always @(negedge clk) begin
    if (ap_start_o) start_cnt <= start_cnt + 1;
    if (tap_WE != 4'h0) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
    int  cyc;
    logic got;
    @(posedge clk); #1;
    axil.awaddr = a; axil.wdata = d; axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      if (axil.awready) begin
        got = 1'b1;
        last_start = ap_start_o;
        last_we = tap_WE;
        if (!axil.wready) chk("wready_with_awready", {31'd0, axil.wready}, 32'd1);
      end
      cyc++;
    end
    if (!got) chk("awready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
  endtask

  task automatic axil_read(input logic [11:0] a, input logic [31:0] exp, input int exp_lat,
                           input int hold, input logic done_pulse, input string nm);
    int lat;
    logic seen;
    logic [31:0] first;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    axil.araddr = a; axil.arvalid = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (axil.arready) axil.arvalid = 1'b0;
      if (axil.rvalid) seen = 1'b1;
      else lat++;
    end
    if (!seen) begin
      chk({nm, "_rvalid_timeout"}, 32'd0, 32'd1);
      axil.arvalid = 1'b0;
      void'(exp_q.pop_front());
    end else begin
      chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
      first = axil.rdata;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({nm, "_rdata_stable"}, axil.rdata, first);
        chk({nm, "_rvalid_held"}, {31'd0, axil.rvalid}, 32'd1);
      end
      axil.rready = 1'b1;
      eng_done = done_pulse;
      chk(nm, first, exp_q.pop_front());
      @(posedge clk); #1;
      axil.rready = 1'b0;
      eng_done = 1'b0;
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; eng_done = 1'b1;
    @(posedge clk); #1; eng_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, w0;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0; axil.rready = 1'b0;
    axil.awaddr = 12'h000; axil.wdata = 32'd0; axil.araddr = 12'h000;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_awready", {31'd0, axil.awready}, 32'd0);
    chk("rst_rvalid", {31'd0, axil.rvalid}, 32'd0);
    chk("rst_rdata", axil.rdata, 32'd0);
    chk("rst_tap_EN", {31'd0, tap_EN}, 32'd0);
    chk("rst_tap_A", {20'd0, tap_A}, 32'd0);
    chk("rst_eng_own", {31'd0, eng_own}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("tap_EN_after_reset", {31'd0, tap_EN}, 32'd1);

    // Table: reset-state reads, tap load/readback, boundaries, length.
    tbl.push_back('{1'b0, 12'h000, 32'h4, 0});
    tbl.push_back('{1'b0, 12'h010, 32'h0, 0});
    for (int i = 0; i < 11; i++) tbl.push_back('{1'b1, 12'(32'h20 + 4 * i), 32'(coef[i]), 0});
    for (int i = 0; i < 11; i++) tbl.push_back('{1'b0, 12'(32'h20 + 4 * i), 32'(coef[i]), (i == 3) ? 3 : 0});
    tbl.push_back('{1'b1, 12'h04C, 32'd77, 0});
    tbl.push_back('{1'b0, 12'h04C, 32'h0, 0});
    tbl.push_back('{1'b1, 12'h080, 32'h1234, 0});
    tbl.push_back('{1'b0, 12'h080, 32'h0, 0});
    tbl.push_back('{1'b1, 12'h010, 32'd600, 0});
    tbl.push_back('{1'b0, 12'h010, 32'd600, 0});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) axil_write(tbl[i].addr, tbl[i].data);
      else axil_read(tbl[i].addr, tbl[i].data, 2, tbl[i].hold, 1'b0, "tbl_read");
    end
    chk("tap_write_strobes", 32'(we_cnt), 32'd11);

    // Start with data_length=600.
    s0 = start_cnt;
    axil_write(12'h000, 32'd1);
    chk("start_pulse_cycle", {31'd0, last_start}, 32'd1);
    repeat (3) @(negedge clk);
    chk("start_pulse_count", 32'(start_cnt - s0), 32'd1);
    chk("eng_own_run", {31'd0, eng_own}, 32'd1);
    chk("tap_A_engine", {20'd0, tap_A}, 32'h014);
    chk("data_length_o", data_length_o, 32'd600);
    axil_read(12'h000, 32'h0, 2, 0, 1'b0, "ctrl_run");

    // Blocked accesses during RUN.
    w0 = we_cnt; s0 = start_cnt;
    axil_write(12'h024, 32'd5);
    axil_write(12'h010, 32'd7);
    axil_write(12'h000, 32'd1);
    repeat (2) @(negedge clk);
    chk("no_tap_WE_in_run", 32'(we_cnt - w0), 32'd0);
    chk("no_restart_in_run", 32'(start_cnt - s0), 32'd0);
    axil_read(12'h024, 32'hFFFF_FFFF, 2, 0, 1'b0, "tap_read_run");
    axil_read(12'h010, 32'd600, 2, 0, 1'b0, "len_kept_run");

    // Done, then idle after the done has been read once.
    pulse_done();
    @(negedge clk);
    chk("eng_own_done", {31'd0, eng_own}, 32'd0);
    axil_read(12'h000, 32'h6, 2, 0, 1'b0, "ctrl_done");
    axil_read(12'h000, 32'h4, 2, 0, 1'b0, "ctrl_idle");
    axil_read(12'h024, 32'hFFFF_FFF6, 2, 0, 1'b0, "tap_kept");

    // Zero length start is ignored.
    s0 = start_cnt;
    axil_write(12'h010, 32'd0);
    axil_write(12'h000, 32'd1);
    repeat (2) @(negedge clk);
    chk("zero_len_no_start", 32'(start_cnt - s0), 32'd0);
    axil_read(12'h000, 32'h4, 2, 0, 1'b0, "ctrl_zero_len");

    // eng_done in the cycle a 0x00 read completes: old value, done sticks.
    axil_write(12'h010, 32'd5);
    axil_write(12'h000, 32'd1);
    axil_read(12'h000, 32'h0, 2, 0, 1'b1, "ctrl_done_race");
    axil_read(12'h000, 32'h6, 2, 0, 1'b0, "ctrl_done_sticky");
    axil_read(12'h000, 32'h4, 2, 0, 1'b0, "ctrl_idle_again");

    // Write and read of the same tap in the same cycle: write first.
    fork
      axil_write(12'h02C, 32'h0000_ABCD);
      axil_read(12'h02C, 32'h0000_ABCD, 3, 0, 1'b0, "collide_read");
    join

    // Reset in the middle of a tap write issued in DONE.
    axil_write(12'h000, 32'd1);
    pulse_done();
    @(posedge clk); #1;
    axil.awaddr = 12'h028; axil.wdata = 32'h55; axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    @(posedge clk); #2;
    chk("midwrite_tap_WE", {28'd0, tap_WE}, 32'hF);
    rst_n = 1'b0;
    #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    chk("rst_mid_tap_WE", {28'd0, tap_WE}, 32'h0);
    chk("rst_mid_awready", {31'd0, axil.awready}, 32'd0);
    chk("rst_mid_tap_EN", {31'd0, tap_EN}, 32'd0);
    chk("rst_mid_tap_Di", tap_Di, 32'd0);
    chk("rst_mid_tap_A", {20'd0, tap_A}, 32'd0);
    chk("rst_mid_len", data_length_o, 32'd0);
    chk("rst_mid_start", {31'd0, ap_start_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axil_read(12'h000, 32'h4, 2, 0, 1'b0, "ctrl_after_rst");
    axil_read(12'h010, 32'h0, 2, 0, 1'b0, "len_after_rst");
    axil_read(12'h028, 32'hFFFF_FFF7, 2, 0, 1'b0, "tap_not_written");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
